multi_lane_adder_acc: RTL
=========================

Name: multi_lane_adder_acc

Overview:
- Parametrised multi-lane registered adder with an optional accumulate stage. Generalises the single-bit y + cin + noise adder used in backend tests.
- Each lane adds two operands plus a carry-in, registers the result, and can accumulate it across cycles in wrap or saturate mode.
- Exposes a sticky invariant flag (check_ok) so formal backends (BTOR/SMT) have a property target.
- Sits as a leaf test block feeding formal-backend regressions.

Parameters:
- WIDTH, 4, operand/sum width per lane (>=1)
- LANES, 2, number of independent adder lanes (>=1)
- SAT, 0, 0 = accumulator wraps mod 2^WIDTH; 1 = accumulator saturates at 2^WIDTH-1
- CNT_W, 8, width of accepted-sample counter

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- in_valid  input  1  operands valid this cycle
- a  input  LANES*WIDTH  lane operand A; lane i = a[i*WIDTH +: WIDTH]
- b  input  LANES*WIDTH  lane operand B, same packing
- cin  input  LANES  per-lane carry-in
- acc_en  input  1  1 = accumulate stage-1 result into acc; 0 = load it
- clr  input  1  clear accumulators and counter (no reset of check_ok)
- out_valid  output  1  sum/cout valid
- sum  output  LANES*WIDTH  accumulator value per lane
- cout  output  LANES  per-lane carry/overflow of the last update
- ovf_sticky  output  LANES  set on any lane overflow since last rst/clr
- count  output  CNT_W  number of accepted samples, wraps
- check_ok  output  1  sticky invariant flag

Behaviour:
- Reset (rst=1 at clk edge): all outputs 0 except check_ok=1; stage-1 registers and valid pipe 0. rst has priority over clr and in_valid.
- Stage 1, on in_valid=1: s1[i] <= a[i] + b[i] + cin[i], computed WIDTH+1 bits wide. v1 <= in_valid every cycle.
- Stage 2, when v1=1, per lane, t = acc_en ? sum[i] + s1[i] : s1[i], computed WIDTH+2 bits wide.
  - Overflow is defined as t > 2^WIDTH-1.
  - SAT=0: sum[i] <= t mod 2^WIDTH.
  - SAT=1: sum[i] <= overflow ? all-ones : t.
  - cout[i] <= overflow.
  - ovf_sticky[i] <= ovf_sticky[i] | overflow.
  - count <= count+1, wrapping at 2^CNT_W.
- When v1=0: sum, cout, ovf_sticky and count hold.
- out_valid <= v1. Latency from in_valid to out_valid is 2 cycles.
- Throughput is 1 sample/cycle, with no backpressure.
- clr=1 (rst=0):
  - sum, cout, ovf_sticky and count are cleared to 0, and out_valid is cleared to 0.
  - Stage-1 data still captures. A sample in stage 1 is dropped, not accumulated.
  - clr wins over a simultaneous v1.
- check_ok:
  - Cleared to 0, and held until rst, if any lane violates one of these invariants:
    - SAT=1 and cout[i]=1 while sum[i] != all-ones.
    - ovf_sticky[i]=0 while cout[i]=1.
  - A correct implementation never clears it. It is the formal assertion target.
- Lanes are fully independent; no carry crosses lanes.
- WIDTH=1, LANES=1, SAT=0 must reduce to A <= y + cin + noise, truncated to 1 bit.

Test Plan:
- Latency and reset: rst for 2 cycles, then in_valid=1, a=3, b=4, cin=1, acc_en=0 (lane 0).
  - Two cycles later: out_valid=1, sum lane0=8, cout=0, count=1, check_ok=1.
- Wrap accumulate (SAT=0, WIDTH=4): load 9, then accumulate 9 with acc_en=1.
  - sum=2, cout=1, ovf_sticky=1.
- Saturate accumulate (SAT=1, WIDTH=4): load 12, then accumulate 15+0+1.
  - sum=15, cout=1, ovf_sticky=1, check_ok=1.
- Lane independence (LANES=2): lane0 a=15, b=1; lane1 a=1, b=1.
  - lane0 sum=0 with cout=1 (SAT=0); lane1 sum=2 with cout=0.
- clr mid-stream: back-to-back in_valid samples, clr asserted in the cycle v1=1.
  - Next cycle: sum=0, count=0, out_valid=0, ovf_sticky=0, and that sample is lost.
  - The following sample is accumulated from 0.
- Counter wrap (CNT_W=2): 5 valid samples.
  - count=1.
  - rst mid-burst zeroes everything and suppresses out_valid for the in-flight sample.

Source files
------------

// File: rtl/multi_lane_adder_acc_if.sv
// Operand/result bundle for multi_lane_adder_acc.
// Lane i occupies bits [i*WIDTH +: WIDTH] of a, b and sum.
interface multi_lane_adder_acc_if #(
  parameter int WIDTH = 4,
  parameter int LANES = 2,
  parameter int CNT_W = 8
);
  logic                   in_valid;
  logic [LANES*WIDTH-1:0] a;
  logic [LANES*WIDTH-1:0] b;
  logic [LANES-1:0]       cin;
  logic                   acc_en;
  logic                   clr;
  logic                   out_valid;
  logic [LANES*WIDTH-1:0] sum;
  logic [LANES-1:0]       cout;
  logic [LANES-1:0]       ovf_sticky;
  logic [CNT_W-1:0]       count;
  logic                   check_ok;

  modport master (
    output in_valid, a, b, cin, acc_en, clr,
    input  out_valid, sum, cout, ovf_sticky, count, check_ok
  );

  modport slave (
    input  in_valid, a, b, cin, acc_en, clr,
    output out_valid, sum, cout, ovf_sticky, count, check_ok
  );
endinterface

// File: rtl/multi_lane_adder_acc.sv
// Multi-lane registered adder with wrap/saturate accumulator and a sticky
// invariant flag (check_ok) intended as a formal property target.
module multi_lane_adder_acc #(
  parameter int WIDTH = 4,
  parameter int LANES = 2,
  parameter int SAT   = 0,
  parameter int CNT_W = 8
) (
  input logic                  clk,
  input logic                  rst,
  multi_lane_adder_acc_if.slave bus
);

  localparam logic [WIDTH-1:0] ALL_ONES = '1;

  logic [LANES-1:0][WIDTH:0]   s1_q, s1_d;
  logic                        v1_q, v1_d;
  logic [LANES-1:0][WIDTH-1:0] sum_q, sum_d;
  logic [LANES-1:0]            cout_q, cout_d;
  logic [LANES-1:0]            ovf_q, ovf_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic                        out_valid_q, out_valid_d;
  logic                        check_ok_q, check_ok_d;

  logic [LANES-1:0][WIDTH+1:0] t;
  logic [LANES-1:0]            lane_ovf;
  logic [LANES-1:0]            viol;

  // Stage 1: per-lane a + b + cin, one bit wider than the operands
  always_comb begin
    s1_d = s1_q;
    v1_d = bus.in_valid;
    if (bus.in_valid) begin
      for (int i = 0; i < LANES; i++) begin
        s1_d[i] = (WIDTH+1)'(bus.a[i*WIDTH +: WIDTH])
                + (WIDTH+1)'(bus.b[i*WIDTH +: WIDTH])
                + (WIDTH+1)'(bus.cin[i]);
      end
    end
  end

  // Stage 2 candidate: two extra bits so sum + s1 can never wrap
  always_comb begin
    t        = '0;
    lane_ovf = '0;
    for (int i = 0; i < LANES; i++) begin
      t[i]        = (WIDTH+2)'(s1_q[i])
                  + (bus.acc_en ? (WIDTH+2)'(sum_q[i]) : (WIDTH+2)'(0));
      lane_ovf[i] = |t[i][WIDTH+1:WIDTH];
    end
  end

  always_comb begin
    sum_d       = sum_q;
    cout_d      = cout_q;
    ovf_d       = ovf_q;
    cnt_d       = cnt_q;
    out_valid_d = v1_q;
    if (bus.clr) begin
      sum_d       = '0;
      cout_d      = '0;
      ovf_d       = '0;
      cnt_d       = '0;
      out_valid_d = 1'b0;
    end else if (v1_q) begin
      for (int i = 0; i < LANES; i++) begin
        sum_d[i] = ((SAT != 0) && lane_ovf[i]) ? ALL_ONES : t[i][WIDTH-1:0];
      end
      cout_d = lane_ovf;
      ovf_d  = ovf_q | lane_ovf;
      cnt_d  = cnt_q + CNT_W'(1);
    end
  end

  // Invariants are evaluated on the registered outputs as seen externally
  always_comb begin
    viol = '0;
    for (int i = 0; i < LANES; i++) begin
      viol[i] = (cout_q[i] && !ovf_q[i])
              || ((SAT != 0) && cout_q[i] && (sum_q[i] != ALL_ONES));
    end
    check_ok_d = check_ok_q & ~(|viol);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q        <= '0;
      v1_q        <= 1'b0;
      sum_q       <= '0;
      cout_q      <= '0;
      ovf_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      check_ok_q  <= 1'b1;
    end else begin
      s1_q        <= s1_d;
      v1_q        <= v1_d;
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      check_ok_q  <= check_ok_d;
    end
  end

  assign bus.out_valid  = out_valid_q;
  assign bus.sum        = sum_q;
  assign bus.cout       = cout_q;
  assign bus.ovf_sticky = ovf_q;
  assign bus.count      = cnt_q;
  assign bus.check_ok   = check_ok_q;

endmodule
